morse_from_signal: RTL and testbench

Morse receiver: samples a single on/off key line (button or photodetector), measures mark and space durations in units of `UNIT_CYCLES`, classifies each mark as dot or dash, and assembles one character. On a letter gap it emits the character as a 5-bit pattern plus a 3-bit length. The pattern/length encoding is the same one the LED transmitter consumes, so the two blocks loop back directly.

---
 rtl/morse_from_signal_if.sv | 28 ++
 rtl/morse_from_signal.sv | 154 +++++++++++++++
 tb/tb_morse_from_signal.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/morse_from_signal_if.sv
// Key-line input and decoded-character outputs of the Morse receiver.
// The receiver takes the slave side; a consumer or bench takes the master side.
interface morse_from_signal_if;
  logic       i_Signal;
  logic [4:0] o_Morse_Pattern;
  logic [2:0] o_Morse_Length;
  logic       o_Valid;
  logic       o_Error;
  logic       o_Busy;

  modport master (
    output i_Signal,
    input  o_Morse_Pattern,
    input  o_Morse_Length,
    input  o_Valid,
    input  o_Error,
    input  o_Busy
  );

  modport slave (
    input  i_Signal,
    output o_Morse_Pattern,
    output o_Morse_Length,
    output o_Valid,
    output o_Error,
    output o_Busy
  );
endinterface

// File: rtl/morse_from_signal.sv
// Morse receiver: times marks and spaces on a key line in units of UNIT_CYCLES,
// classifies dots and dashes and emits one character per letter gap.
module morse_from_signal #(
  parameter int UNIT_CYCLES = 6250000
) (
  input logic               i_Clock,
  input logic               i_Reset,
  morse_from_signal_if.slave bus
);

  localparam int CW = $clog2(2 * UNIT_CYCLES + 1);

  localparam logic [CW-1:0] GLITCH = CW'(UNIT_CYCLES / 4);
  localparam logic [CW-1:0] DASH   = CW'(2 * UNIT_CYCLES);
  localparam logic [CW-1:0] GAP_M1 = CW'(2 * UNIT_CYCLES - 1);
  localparam logic [CW-1:0] ONE    = CW'(1);
  localparam logic [2:0]    MAX_SYMBOLS = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MARK,
    S_SPACE
  } state_t;

  // Two-flop synchronizer; sig_q is the only view of the key line the FSM uses.
  logic sync1_q;
  logic sig_q;

  state_t        state_q,   state_d;
  logic [CW-1:0] count_q,   count_d;
  logic [4:0]    acc_q,     acc_d;
  logic [2:0]    cnt_q,     cnt_d;
  logic          ovf_q,     ovf_d;
  logic [4:0]    pattern_q, pattern_d;
  logic [2:0]    length_q,  length_d;
  logic          error_q,   error_d;
  logic          valid_q,   valid_d;

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    pattern_d = pattern_q;
    length_d  = length_q;
    error_d   = error_q;
    valid_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        count_d = '0;
        acc_d   = '0;
        cnt_d   = '0;
        ovf_d   = 1'b0;
        if (sig_q) begin
          state_d = S_MARK;
          count_d = ONE;
        end
      end

      S_MARK: begin
        if (sig_q) begin
          // Saturate at DASH: anything that long is a dash, so no timeout.
          if (count_q != DASH) begin
            count_d = count_q + ONE;
          end
        end else if (count_q < GLITCH) begin
          // Too short to be a symbol; resume whatever came before it.
          if (cnt_q != 3'd0) begin
            state_d = S_SPACE;
            count_d = ONE;
          end else begin
            state_d = S_IDLE;
            count_d = '0;
          end
        end else begin
          if (cnt_q < MAX_SYMBOLS) begin
            acc_d[3'd4 - cnt_q] = (count_q >= DASH);
            cnt_d               = cnt_q + 3'd1;
          end else begin
            ovf_d = 1'b1;
          end
          state_d = S_SPACE;
          count_d = ONE;
        end
      end

      S_SPACE: begin
        if (sig_q) begin
          state_d = S_MARK;
          count_d = ONE;
        end else if (count_q == GAP_M1) begin
          // The GAP-th low sample closes the character.
          pattern_d = acc_q;
          length_d  = cnt_q;
          error_d   = ovf_q;
          valid_d   = 1'b1;
          acc_d     = '0;
          cnt_d     = '0;
          ovf_d     = 1'b0;
          count_d   = '0;
          state_d   = S_IDLE;
        end else begin
          count_d = count_q + ONE;
        end
      end

      default: begin
        state_d = S_IDLE;
        count_d = '0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, regardless of statement order.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      sync1_q   <= 1'b0;
      sig_q     <= 1'b0;
      state_q   <= S_IDLE;
      count_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      pattern_q <= '0;
      length_q  <= '0;
      error_q   <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      sync1_q   <= bus.i_Signal;
      sig_q     <= sync1_q;
      state_q   <= state_d;
      count_q   <= count_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      pattern_q <= pattern_d;
      length_q  <= length_d;
      error_q   <= error_d;
      valid_q   <= valid_d;
    end
  end

  assign bus.o_Morse_Pattern = pattern_q;
  assign bus.o_Morse_Length  = length_q;
  assign bus.o_Error         = error_q;
  assign bus.o_Valid         = valid_q;
  assign bus.o_Busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_morse_from_signal.sv
// Directed bench for morse_from_signal with UNIT_CYCLES = 16 (GLITCH 4, DASH/GAP 32);
// expected characters are queued by the stimulus and consumed by a monitor on o_Valid.
module tb_morse_from_signal;

  localparam int UNIT = 16;
  localparam int GAP  = 2 * UNIT;

  typedef struct {
    logic [4:0] pat;
    logic [2:0] len;
    logic       err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   last_valid_cyc = 0;
  int   fall_cyc = 0;
  exp_t sb[$];

  morse_from_signal_if bus ();

  morse_from_signal #(.UNIT_CYCLES(UNIT)) dut (
    .i_Clock (clk),
    .i_Reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every strobe must match the oldest queued expectation.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (bus.o_Valid === 1'b1) begin
      last_valid_cyc = cyc;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid: got pattern %b length %0d error %b expected no strobe (cycle %0d)",
                 bus.o_Morse_Pattern, bus.o_Morse_Length, bus.o_Error, cyc);
      end else begin
        e = sb.pop_front();
        check("pattern", 32'(bus.o_Morse_Pattern), 32'(e.pat));
        check("length",  32'(bus.o_Morse_Length),  32'(e.len));
        check("error",   32'(bus.o_Error),         32'(e.err));
      end
    end
  end

  task automatic key(input logic level, input int n);
    bus.i_Signal = level;
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_char(input logic [4:0] pat, input logic [2:0] len, input logic err);
    exp_t e;
    e.pat = pat;
    e.len = len;
    e.err = err;
    sb.push_back(e);
  endtask

  task automatic drain(input string name);
    int w = 0;
    while (sb.size() != 0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    check(name, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_pattern"}, 32'(bus.o_Morse_Pattern), 32'd0);
    check({name, "_length"},  32'(bus.o_Morse_Length),  32'd0);
    check({name, "_error"},   32'(bus.o_Error),         32'd0);
    check({name, "_valid"},   32'(bus.o_Valid),         32'd0);
    check({name, "_busy"},    32'(bus.o_Busy),          32'd0);
  endtask

  initial begin
    bus.i_Signal = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_all_zero("reset");

    // "A": dot, dash (48 saturates), latency from last falling edge.
    key(1'b1, 16);
    key(1'b0, 16);
    key(1'b1, 48);
    expect_char(5'b01000, 3'd2, 1'b0);
    fall_cyc = cyc;
    key(1'b0, 60);
    drain("A_drain");
    check("A_latency", 32'(last_valid_cyc - fall_cyc), 32'(GAP + 2));

    // Dash threshold: 31 is a dot, 32 is a dash.
    key(1'b1, 31);
    expect_char(5'b00000, 3'd1, 1'b0);
    key(1'b0, 40);
    key(1'b1, 32);
    expect_char(5'b10000, 3'd1, 1'b0);
    key(1'b0, 40);
    drain("thresh_drain");

    // Lone glitch: no strobe, busy drops.
    key(1'b1, 3);
    key(1'b0, 10);
    check("glitch_busy", 32'(bus.o_Busy), 32'd0);
    key(1'b0, 40);
    // Glitch inside a space restarts the space.
    key(1'b1, 16);
    key(1'b0, 10);
    key(1'b1, 3);
    expect_char(5'b00000, 3'd1, 1'b0);
    key(1'b0, 40);
    drain("glitch_drain");

    // Glitch threshold: 4 accepted as a dot.
    key(1'b1, 4);
    expect_char(5'b00000, 3'd1, 1'b0);
    key(1'b0, 40);
    drain("glitch_edge_drain");

    // Gap boundary: 31 continues the character, 32 splits it.
    key(1'b1, 16);
    key(1'b0, 31);
    key(1'b1, 40);
    expect_char(5'b01000, 3'd2, 1'b0);
    key(1'b0, 40);
    drain("gap31_drain");
    key(1'b1, 16);
    expect_char(5'b00000, 3'd1, 1'b0);
    key(1'b0, 32);
    key(1'b1, 40);
    expect_char(5'b10000, 3'd1, 1'b0);
    key(1'b0, 40);
    drain("gap32_drain");

    // Overflow: dash then five dots; first five kept, error flagged.
    key(1'b1, 40);
    for (int i = 0; i < 5; i++) begin
      key(1'b0, 16);
      key(1'b1, 16);
    end
    expect_char(5'b10000, 3'd5, 1'b1);
    key(1'b0, 40);
    drain("ovf_drain");
    check("ovf_hold_length", 32'(bus.o_Morse_Length), 32'd5);
    check("ovf_hold_error",  32'(bus.o_Error),        32'd1);

    // Reset mid-character discards it and clears the held outputs.
    key(1'b1, 16);
    key(1'b0, 16);
    key(1'b1, 40);
    key(1'b0, 10);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("midreset");
    key(1'b0, 50);

    // "E" after reset.
    key(1'b1, 16);
    expect_char(5'b00000, 3'd1, 1'b0);
    key(1'b0, 50);
    drain("E_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
